adsr_envelope: RTL and testbench
================================

// Module: adsr_envelope
// PURPOSE
//  Per-voice ADSR envelope generator and VCA, directly downstream of the oscillator.
//  Takes one oscillator waveform sample (sine/pulse/triangle, selected upstream) and a
//  note gate. Outputs the sample scaled by an attack/decay/sustain/release envelope
//  advanced once per audio sample tick. Its output feeds the voice mixer.
// PARAMETERS
//  AUDIO_BIT_WIDTH  24  sample width, two's complement signed (in and out)
//  ENV_WIDTH        16  envelope level width; ENV_MAX = 2**ENV_WIDTH-1 (full scale)
// PORTS
//  clock_50_000_000  in   1                system clock; all state on posedge
//  reset             in   1                asynchronous, active-high reset
//  sample_tick       in   1                1-cycle strobe at audio sample rate
//  note_on           in   1                gate level; high = key held
//  attack_step       in   ENV_WIDTH        level increment per tick in ATTACK
//  decay_step        in   ENV_WIDTH        level decrement per tick in DECAY
//  sustain_level     in   ENV_WIDTH        SUSTAIN target level
//  release_step      in   ENV_WIDTH        level decrement per tick in RELEASE
//  sample_in         in   AUDIO_BIT_WIDTH  oscillator sample (signed)
//  sample_out        out  AUDIO_BIT_WIDTH  enveloped sample (signed), registered
//  envelope          out  ENV_WIDTH        current envelope level, registered
//  active            out  1                high whenever state != IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  - Reset: state=IDLE, envelope=0, sample_out=0, active=0, gate_q=0.
//    Reset asserted mid-note forces these values immediately.
//    If note_on is high at deassert, the first clock sees a rising edge and enters ATTACK.
//  - gate_q = note_on registered each clock.
//    rise = note_on & ~gate_q; fall = ~note_on & gate_q.
//  - States IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
//    Gate transitions are evaluated every clock. Level arithmetic happens only on sample_tick.
//  - rise (from any state, including RELEASE/DECAY) -> ATTACK.
//    Retrigger keeps the current level; the level is not reset to 0.
//  - fall while in ATTACK/DECAY/SUSTAIN -> RELEASE. Gate low in IDLE: stay IDLE.
//  - rise/fall in the same cycle as sample_tick: the state change wins.
//    No level step is taken that cycle.
//  - ATTACK on tick: env = min(env+attack_step, ENV_MAX), computed with ENV_WIDTH+1 bits.
//    If env reaches ENV_MAX -> DECAY. attack_step==0: env=ENV_MAX, -> DECAY same tick.
//  - DECAY on tick: env = max(env-decay_step, sustain_level), no underflow.
//    If env reaches sustain_level -> SUSTAIN. decay_step==0: instant.
//    If sustain_level >= env on entry, env=sustain_level, -> SUSTAIN on the next tick.
//  - SUSTAIN on tick: env = sustain_level (tracks live changes).
//    sustain_level==0 holds env 0 with active=1 until the gate falls.
//  - RELEASE on tick: env = max(env-release_step, 0).
//    If env reaches 0 -> IDLE. release_step==0: env=0, -> IDLE same tick.
//  - IDLE: env held at 0.
//  - VCA: product = signed(sample_in) * signed({1'b0,envelope}).
//    sample_out <= product >>> ENV_WIDTH (arithmetic shift, truncated to AUDIO_BIT_WIDTH).
//    Updated every clock; 1-cycle latency from sample_in; uses the registered envelope.
//    No overflow is possible because envelope < 2**ENV_WIDTH.
//  - active and envelope are registered, consistent with state on the same cycle.
// TESTING (AUDIO_BIT_WIDTH=24, ENV_WIDTH=16, tick every 4 clocks)
//  1 Attack: note_on=1, attack_step=16384 -> env 16384,32768,49152,65535 on ticks 1-4.
//    DECAY on tick 4; active=1 from the cycle after the rise.
//  2 Decay/sustain: decay_step=8192, sustain=32768 -> env 57343,49151,40959,32768.
//    SUSTAIN reached; env stays 32768 over 10 further ticks.
//  3 Release: note_on=0 in SUSTAIN, release_step=16384 -> env 16384 then 0.
//    IDLE after tick 2; active=0.
//  4 Retrigger: note_on 0->1 in RELEASE at env=16384 -> ATTACK with no drop.
//    Next tick env=32768. Gate rise coincident with a tick: no step that cycle.
//  5 VCA: env=32768. sample_in=24'sh400000 -> sample_out=24'sh200000.
//    sample_in=-24'sh400000 -> 24'shE00000. env=0 -> sample_out=0.
//  6 Reset mid-ATTACK with note_on held -> env=0, sample_out=0, active=0 immediately.
//    After deassert: ATTACK, first tick env=attack_step. Also check steps=0 (instant).

Source files
------------

// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: voice control/sample bus between the note logic and the ADSR envelope/VCA.
interface adsr_envelope_if #(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int ENV_WIDTH = 16
);
    logic sample_tick;
    logic note_on;
    logic [ENV_WIDTH-1:0] attack_step;
    logic [ENV_WIDTH-1:0] decay_step;
    logic [ENV_WIDTH-1:0] sustain_level;
    logic [ENV_WIDTH-1:0] release_step;
    logic signed [AUDIO_BIT_WIDTH-1:0] sample_in;
    logic signed [AUDIO_BIT_WIDTH-1:0] sample_out;
    logic [ENV_WIDTH-1:0] envelope;
    logic active;
    modport master (
        output sample_tick, note_on, attack_step, decay_step, sustain_level, release_step, sample_in,
        input sample_out, envelope, active
    );
    modport slave (
        input sample_tick, note_on, attack_step, decay_step, sustain_level, release_step, sample_in,
        output sample_out, envelope, active
    );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator and VCA scaling the oscillator sample.
module adsr_envelope #(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int ENV_WIDTH = 16
) (
    input logic clock_50_000_000,
    input logic reset,
    adsr_envelope_if.slave voice
);
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
    state_t state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic gate_q, rise, fall;
    logic [ENV_WIDTH:0] sum;
    logic signed [AUDIO_BIT_WIDTH+ENV_WIDTH:0] prod;
    logic signed [AUDIO_BIT_WIDTH-1:0] sample_q, sample_d;

    assign rise = voice.note_on & ~gate_q;
    assign fall = ~voice.note_on & gate_q;
    assign sum = {1'b0, env_q} + {1'b0, voice.attack_step};
    // envelope is zero-extended so it always scales as a positive gain below unity
    assign prod = $signed(voice.sample_in) * $signed({1'b0, env_q});
    assign sample_d = AUDIO_BIT_WIDTH'(prod >>> ENV_WIDTH);

    always_comb begin
        state_d = state_q;
        env_d = env_q;
        if (rise) state_d = ATTACK;
        else if (fall && state_q inside {ATTACK, DECAY, SUSTAIN}) state_d = RELEASE;
        else if (voice.sample_tick) begin
            case (state_q)
                ATTACK: begin
                    env_d = (voice.attack_step == '0 || sum >= {1'b0, ENV_MAX}) ? ENV_MAX : sum[ENV_WIDTH-1:0];
                    state_d = (env_d == ENV_MAX) ? DECAY : ATTACK;
                end
                DECAY: begin
                    env_d = (voice.decay_step == '0 || env_q <= voice.sustain_level ||
                             env_q - voice.sustain_level <= voice.decay_step) ? voice.sustain_level : env_q - voice.decay_step;
                    state_d = (env_d == voice.sustain_level) ? SUSTAIN : DECAY;
                end
                SUSTAIN: env_d = voice.sustain_level;
                RELEASE: begin
                    env_d = (voice.release_step == '0 || env_q <= voice.release_step) ? '0 : env_q - voice.release_step;
                    state_d = (env_d == '0) ? IDLE : RELEASE;
                end
                default: env_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            env_q <= '0;
            gate_q <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            env_q <= env_d;
            gate_q <= voice.note_on;
            sample_q <= sample_d;
        end
    end

    assign voice.envelope = env_q;
    assign voice.active = state_q != IDLE;
    assign voice.sample_out = sample_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: scoreboard-driven directed checks of the ADSR envelope and VCA.
module tb_adsr_envelope;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    typedef struct {string tag; logic [31:0] val;} exp_t;
    exp_t sb[$];

    adsr_envelope_if #(.AUDIO_BIT_WIDTH(24), .ENV_WIDTH(16)) bus ();
    adsr_envelope #(.AUDIO_BIT_WIDTH(24), .ENV_WIDTH(16)) dut (
        .clock_50_000_000(clk),
        .reset(rst),
        .voice(bus)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic push(string tag, logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop(logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got %0d want a queued entry", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic expect_state(string tag, logic [31:0] env, logic [31:0] act);
        push({tag, "_env"}, env);
        push({tag, "_act"}, act);
        pop({16'h0, bus.envelope});
        pop({31'h0, bus.active});
    endtask

    task automatic tick(string tag, logic [31:0] env, logic [31:0] act);
        push({tag, "_env"}, env);
        push({tag, "_act"}, act);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        pop({16'h0, bus.envelope});
        pop({31'h0, bus.active});
        repeat (3) @(negedge clk);
    endtask

    task automatic vca(string tag, logic [23:0] s, logic [23:0] exp);
        push(tag, {8'h0, exp});
        bus.sample_in = s;
        @(negedge clk);
        pop({8'h0, bus.sample_out});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] att[4] = '{16384, 32768, 49152, 65535};
        logic [31:0] dec[4] = '{57343, 49151, 40959, 32768};
        bus.sample_tick = 1'b0;
        bus.note_on = 1'b0;
        bus.attack_step = 16'd16384;
        bus.decay_step = 16'd8192;
        bus.sustain_level = 16'd32768;
        bus.release_step = 16'd16384;
        bus.sample_in = 24'h400000;
        repeat (2) @(negedge clk);
        expect_state("reset", 0, 0);
        push("reset_out", 0);
        pop({8'h0, bus.sample_out});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_state("idle_hold", 0, 0);
        tick("idle_tick", 0, 0);
        bus.note_on = 1'b1;
        @(negedge clk);
        expect_state("rise", 0, 1);
        for (int i = 0; i < 4; i++) tick($sformatf("att%0d", i + 1), att[i], 1);
        for (int i = 0; i < 4; i++) tick($sformatf("dec%0d", i + 1), dec[i], 1);
        for (int i = 0; i < 10; i++) tick($sformatf("sus%0d", i), 32768, 1);
        vca("vca_pos", 24'h400000, 24'h200000);
        vca("vca_neg", 24'hC00000, 24'hE00000);
        bus.note_on = 1'b0;
        @(negedge clk);
        tick("rel1", 16384, 1);
        tick("rel2", 0, 0);
        vca("vca_zero", 24'h400000, 24'h000000);
        bus.note_on = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) tick($sformatf("ratt%0d", i + 1), att[i], 1);
        for (int i = 0; i < 4; i++) tick($sformatf("rdec%0d", i + 1), dec[i], 1);
        bus.note_on = 1'b0;
        @(negedge clk);
        tick("rel_a", 16384, 1);
        bus.note_on = 1'b1;
        tick("retrig_coinc", 16384, 1);
        tick("retrig_step", 32768, 1);
        bus.note_on = 1'b0;
        tick("fall_coinc", 32768, 1);
        tick("fall_rel", 16384, 1);
        tick("fall_idle", 0, 0);
        bus.note_on = 1'b1;
        @(negedge clk);
        tick("r6_att", 16384, 1);
        bus.sample_in = 24'h400000;
        @(negedge clk);
        vca("r6_vca", 24'h400000, 24'h100000);
        #2 rst = 1'b1;
        #1 expect_state("async_rst", 0, 0);
        push("async_rst_out", 0);
        pop({8'h0, bus.sample_out});
        @(negedge clk);
        rst = 1'b0;
        bus.attack_step = 16'd20000;
        @(negedge clk);
        expect_state("post_rst", 0, 1);
        tick("post_rst_att", 20000, 1);
        bus.attack_step = 16'd0;
        tick("att_inst", 65535, 1);
        bus.decay_step = 16'd0;
        bus.sustain_level = 16'd1000;
        tick("dec_inst", 1000, 1);
        tick("sus_1000", 1000, 1);
        bus.sustain_level = 16'd0;
        tick("sus_zero", 0, 1);
        bus.sustain_level = 16'd5000;
        tick("sus_track", 5000, 1);
        bus.note_on = 1'b0;
        bus.release_step = 16'd0;
        @(negedge clk);
        tick("rel_inst", 0, 0);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
